max7219_serial_rx: RTL and testbench

//  Synthesizable MAX7219-compatible serial receiver: the device end of the display link driven by

---
 rtl/max7219_serial_rx.sv | 149 ++++++++++++++
 tb/tb_max7219_serial_rx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_serial_rx.sv
// MAX7219-compatible serial receiver: synchronizes the LOAD/CLK/DIN link, assembles 16-bit frames
// and maintains the register file. Optional Code-B font decoding is enabled by CODE_B_DECODE_EN.
module max7219_serial_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_serial_din,
  input  logic        i_serial_clk,
  input  logic        i_serial_load,
  output logic [63:0] o_digits,
  output logic [7:0]  o_decode_mode,
  output logic [3:0]  o_intensity,
  output logic [2:0]  o_scan_limit,
  output logic        o_shutdown,
  output logic        o_display_test,
  output logic        o_update_stb,
  output logic        o_frame_err
);

  logic [SYNC_STAGES-1:0] clkSync_q, dinSync_q, loadSync_q;
  logic                   clkPrev_q, loadPrev_q;
  logic                   clkS, dinS, loadS;
  logic                   clkRise, loadRise, shiftEn;
  logic [15:0]            shift_q, shift_d;
  logic [4:0]             count_q, count_d;
  logic                   frameOk, frameErr;
  logic [7:0]             digitReg_q [8];
  logic [7:0]             decode_q;
  logic [3:0]             intensity_q;
  logic [2:0]             scanLimit_q;
  logic                   shutdown_q, displayTest_q;
  logic                   updateStb_q, frameErr_q;
  logic [7:0]             seg;

  assign clkS     = clkSync_q[SYNC_STAGES-1];
  assign dinS     = dinSync_q[SYNC_STAGES-1];
  assign loadS    = loadSync_q[SYNC_STAGES-1];
  assign clkRise  = clkS & ~clkPrev_q;
  assign loadRise = loadS & ~loadPrev_q;
  // A clock edge coinciding with the LOAD edge still counts as "LOAD low" so its bit is kept.
  assign shiftEn  = clkRise & (~loadS | ~loadPrev_q);

  always_comb begin
    shift_d  = shift_q;
    count_d  = count_q;
    frameOk  = 1'b0;
    frameErr = 1'b0;
    if (shiftEn) begin
      shift_d = {shift_q[14:0], dinS};
      if (count_q != 5'd16) count_d = count_q + 5'd1;
    end
    if (loadRise) begin
      if (count_d == 5'd16) frameOk = 1'b1;
      else                  frameErr = 1'b1;
      count_d = 5'd0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      clkSync_q     <= '0;
      dinSync_q     <= '0;
      loadSync_q    <= '0;
      clkPrev_q     <= 1'b0;
      loadPrev_q    <= 1'b0;
      shift_q       <= '0;
      count_q       <= '0;
      for (int i = 0; i < 8; i++) digitReg_q[i] <= '0;
      decode_q      <= '0;
      intensity_q   <= '0;
      scanLimit_q   <= '0;
      shutdown_q    <= 1'b1;
      displayTest_q <= 1'b0;
      updateStb_q   <= 1'b0;
      frameErr_q    <= 1'b0;
    end else begin
      clkSync_q   <= {clkSync_q[SYNC_STAGES-2:0], i_serial_clk};
      dinSync_q   <= {dinSync_q[SYNC_STAGES-2:0], i_serial_din};
      loadSync_q  <= {loadSync_q[SYNC_STAGES-2:0], i_serial_load};
      clkPrev_q   <= clkS;
      loadPrev_q  <= loadS;
      shift_q     <= shift_d;
      count_q     <= count_d;
      updateStb_q <= frameOk;
      frameErr_q  <= frameErr;
      if (frameOk) begin
        case (shift_d[11:8])
          4'h1, 4'h2, 4'h3, 4'h4,
          4'h5, 4'h6, 4'h7, 4'h8: digitReg_q[3'(shift_d[11:8] - 4'd1)] <= shift_d[7:0];
          4'h9:    decode_q      <= shift_d[7:0];
          4'hA:    intensity_q   <= shift_d[3:0];
          4'hB:    scanLimit_q   <= shift_d[2:0];
          4'hC:    shutdown_q    <= ~shift_d[0];
          4'hF:    displayTest_q <= shift_d[0];
          default: ;
        endcase
      end
    end
  end

`ifdef CODE_B_DECODE_EN
  function automatic logic [6:0] codeB(input logic [3:0] v);
    case (v)
      4'h0:    codeB = 7'h7E;
      4'h1:    codeB = 7'h30;
      4'h2:    codeB = 7'h6D;
      4'h3:    codeB = 7'h79;
      4'h4:    codeB = 7'h33;
      4'h5:    codeB = 7'h5B;
      4'h6:    codeB = 7'h5F;
      4'h7:    codeB = 7'h70;
      4'h8:    codeB = 7'h7F;
      4'h9:    codeB = 7'h7B;
      4'hA:    codeB = 7'h01;
      4'hB:    codeB = 7'h4F;
      4'hC:    codeB = 7'h37;
      4'hD:    codeB = 7'h0E;
      4'hE:    codeB = 7'h67;
      default: codeB = 7'h00;
    endcase
  endfunction
`endif

  // Display test overrides shutdown, which overrides the scan limit.
  always_comb begin
    o_digits = '0;
    seg      = '0;
    for (int n = 0; n < 8; n++) begin
      seg = digitReg_q[n];
`ifdef CODE_B_DECODE_EN
      if (decode_q[n]) seg = {digitReg_q[n][7], codeB(digitReg_q[n][3:0])};
`endif
      if (displayTest_q)                        seg = 8'hFF;
      else if (shutdown_q)                      seg = 8'h00;
      else if (n[3:0] > {1'b0, scanLimit_q})    seg = 8'h00;
      o_digits[8*n +: 8] = seg;
    end
  end

  assign o_decode_mode  = decode_q;
  assign o_intensity    = intensity_q;
  assign o_scan_limit   = scanLimit_q;
  assign o_shutdown     = shutdown_q;
  assign o_display_test = displayTest_q;
  assign o_update_stb   = updateStb_q;
  assign o_frame_err    = frameErr_q;

endmodule

// File: tb/tb_max7219_serial_rx.sv
// Self-checking bench for max7219_serial_rx: table-driven frames, hand-written corner cases and
// randomized frames compared against a register-level reference model.
module tb_max7219_serial_rx;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        serDin = 1'b0;
  logic        serClk = 1'b0;
  logic        serLoad = 1'b0;
  logic [63:0] digits;
  logic [7:0]  decodeMode;
  logic [3:0]  intensity;
  logic [2:0]  scanLimit;
  logic        shutdown, displayTest, updateStb, frameErr;

  int passCount = 0;
  int totalCount = 0;
  int stbCount = 0;
  int errCount = 0;

  logic [7:0] mDigit [8];
  logic [7:0] mDecode;
  logic [3:0] mIntensity;
  logic [2:0] mScan;
  logic       mShutdown, mTest;
  logic [6:0] codeBTab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h01, 7'h4F, 7'h37, 7'h0E, 7'h67, 7'h00};

`ifdef CODE_B_DECODE_EN
  localparam logic [7:0] EXP_D0 = 8'hDB;
`else
  localparam logic [7:0] EXP_D0 = 8'h85;
`endif

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    int          expStb;
    int          expErr;
    int          chkIdx;
    logic [7:0]  chkVal;
    logic        expShutdown;
    logic [2:0]  expScan;
  } vec_t;

  vec_t vecs [16];

  max7219_serial_rx #(.SYNC_STAGES(2)) dut (
    .i_clk          (clk),
    .i_reset_n      (rstN),
    .i_serial_din   (serDin),
    .i_serial_clk   (serClk),
    .i_serial_load  (serLoad),
    .o_digits       (digits),
    .o_decode_mode  (decodeMode),
    .o_intensity    (intensity),
    .o_scan_limit   (scanLimit),
    .o_shutdown     (shutdown),
    .o_display_test (displayTest),
    .o_update_stb   (updateStb),
    .o_frame_err    (frameErr)
  );

  always #5 clk = ~clk;

  // Count strobe pulses away from the active edge.
  always @(negedge clk) begin
    if (rstN) begin
      if (updateStb) stbCount++;
      if (frameErr)  errCount++;
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic modelReset();
    for (int i = 0; i < 8; i++) mDigit[i] = 8'h00;
    mDecode = 8'h00; mIntensity = 4'h0; mScan = 3'd0; mShutdown = 1'b1; mTest = 1'b0;
  endtask

  task automatic modelApply(input logic [31:0] bits, input int nbits);
    logic [15:0] f;
    if (nbits < 16) return;
    f = bits[15:0];
    case (f[11:8])
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: mDigit[int'(f[11:8]) - 1] = f[7:0];
      4'h9: mDecode = f[7:0];
      4'hA: mIntensity = f[3:0];
      4'hB: mScan = f[2:0];
      4'hC: mShutdown = ~f[0];
      4'hF: mTest = f[0];
      default: ;
    endcase
  endtask

  function automatic logic [63:0] modelDigits();
    logic [63:0] r;
    logic [7:0]  v;
    r = '0;
    for (int n = 0; n < 8; n++) begin
      if (mTest)           v = 8'hFF;
      else if (mShutdown)  v = 8'h00;
      else if (n > mScan)  v = 8'h00;
      else begin
        v = mDigit[n];
`ifdef CODE_B_DECODE_EN
        if (mDecode[n]) v = {mDigit[n][7], codeBTab[mDigit[n][3:0]]};
`endif
      end
      r[8*n +: 8] = v;
    end
    return r;
  endfunction

  task automatic checkModel(input string tag);
    checkOutput({tag, ".digits"}, digits, modelDigits());
    checkOutput({tag, ".decode"}, 64'(decodeMode), 64'(mDecode));
    checkOutput({tag, ".intensity"}, 64'(intensity), 64'(mIntensity));
    checkOutput({tag, ".scan"}, 64'(scanLimit), 64'(mScan));
    checkOutput({tag, ".shutdown"}, 64'(shutdown), 64'(mShutdown));
    checkOutput({tag, ".test"}, 64'(displayTest), 64'(mTest));
  endtask

  // Shift nbits out MSB first with LOAD low; leaves serial clk low and LOAD low.
  task automatic sendBits(input logic [31:0] bits, input int nbits);
    serLoad = 1'b0;
    waitCycles(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      serDin = bits[i];
      waitCycles(4);
      serClk = 1'b1;
      waitCycles(4);
      serClk = 1'b0;
    end
    waitCycles(4);
  endtask

  task automatic applyStimulus(input logic [31:0] bits, input int nbits);
    sendBits(bits, nbits);
    serLoad = 1'b1;
    waitCycles(10);
  endtask

  initial begin
    int stb0, err0, lat, nb;
    logic [31:0] rb;

    vecs[0]  = '{32'h0C01, 16, 1, 0, 0, 8'h00, 1'b0, 3'd0};
    vecs[1]  = '{32'h0B07, 16, 1, 0, 0, 8'h00, 1'b0, 3'd7};
    vecs[2]  = '{32'h0130, 16, 1, 0, 0, 8'h30, 1'b0, 3'd7};
    vecs[3]  = '{32'h0ABC, 12, 0, 1, 0, 8'h30, 1'b0, 3'd7};
    vecs[4]  = '{32'h0255, 16, 1, 0, 1, 8'h55, 1'b0, 3'd7};
    vecs[5]  = '{32'hF0366, 20, 1, 0, 2, 8'h66, 1'b0, 3'd7};
    vecs[6]  = '{32'h0477, 16, 1, 0, 3, 8'h77, 1'b0, 3'd7};
    vecs[7]  = '{32'h0C00, 16, 1, 0, 0, 8'h00, 1'b1, 3'd7};
    vecs[8]  = '{32'h0F01, 16, 1, 0, 5, 8'hFF, 1'b1, 3'd7};
    vecs[9]  = '{32'h0F00, 16, 1, 0, 5, 8'h00, 1'b1, 3'd7};
    vecs[10] = '{32'h0C01, 16, 1, 0, 0, 8'h30, 1'b0, 3'd7};
    vecs[11] = '{32'h0B02, 16, 1, 0, 3, 8'h00, 1'b0, 3'd2};
    vecs[12] = '{32'h0D12, 16, 1, 0, 2, 8'h66, 1'b0, 3'd2};
    vecs[13] = '{32'h0901, 16, 1, 0, 1, 8'h55, 1'b0, 3'd2};
    vecs[14] = '{32'h0185, 16, 1, 0, 0, EXP_D0, 1'b0, 3'd2};
    vecs[15] = '{32'h0000, 0, 0, 1, 0, EXP_D0, 1'b0, 3'd2};

    modelReset();
    waitCycles(5);
    checkModel("reset");
    checkOutput("reset.stb", 64'(updateStb), 64'd0);
    checkOutput("reset.err", 64'(frameErr), 64'd0);
    rstN = 1'b1;
    waitCycles(20);
    checkModel("idle");
    checkOutput("idle.strobes", 64'(stbCount + errCount), 64'd0);

    for (int v = 0; v < 16; v++) begin
      stb0 = stbCount;
      err0 = errCount;
      applyStimulus(vecs[v].bits, vecs[v].nbits);
      modelApply(vecs[v].bits, vecs[v].nbits);
      checkOutput($sformatf("vec%0d.stb", v), 64'(stbCount - stb0), 64'(vecs[v].expStb));
      checkOutput($sformatf("vec%0d.err", v), 64'(errCount - err0), 64'(vecs[v].expErr));
      checkOutput($sformatf("vec%0d.digit", v), 64'(digits[8*vecs[v].chkIdx +: 8]), 64'(vecs[v].chkVal));
      checkOutput($sformatf("vec%0d.shutdown", v), 64'(shutdown), 64'(vecs[v].expShutdown));
      checkOutput($sformatf("vec%0d.scan", v), 64'(scanLimit), 64'(vecs[v].expScan));
      checkModel($sformatf("vec%0d", v));
    end

    // Strobe latency from the raw LOAD edge.
    sendBits(32'h0A05, 16);
    @(posedge clk);
    #1;
    serLoad = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (updateStb && lat == 0) lat = i;
    end
    modelApply(32'h0A05, 16);
    checkOutput("latency", 64'(lat), 64'd3);
    checkModel("latency");

    // Last serial clock edge and LOAD edge arrive together.
    stb0 = stbCount;
    err0 = errCount;
    serLoad = 1'b0;
    waitCycles(4);
    for (int i = 15; i >= 1; i--) begin
      serDin = 1'(32'h0B07 >> i);
      waitCycles(4);
      serClk = 1'b1;
      waitCycles(4);
      serClk = 1'b0;
    end
    serDin = 1'b1;
    waitCycles(4);
    serClk = 1'b1;
    serLoad = 1'b1;
    waitCycles(4);
    serClk = 1'b0;
    waitCycles(8);
    modelApply(32'h0B07, 16);
    checkOutput("simul.stb", 64'(stbCount - stb0), 64'd1);
    checkOutput("simul.err", 64'(errCount - err0), 64'd0);
    checkModel("simul");

    // Reset in the middle of a frame discards the partial bits.
    sendBits(32'hAB, 8);
    rstN = 1'b0;
    waitCycles(3);
    rstN = 1'b1;
    modelReset();
    waitCycles(5);
    checkModel("midreset");
    stb0 = stbCount;
    err0 = errCount;
    applyStimulus(32'hCD, 8);
    checkOutput("midreset.stb", 64'(stbCount - stb0), 64'd0);
    checkOutput("midreset.err", 64'(errCount - err0), 64'd1);
    checkModel("midreset.after");

    for (int r = 0; r < 40; r++) begin
      rb = $urandom;
      nb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 24)) : 16;
      if (rb[11:8] == 4'hF && $urandom_range(0, 1) == 1) rb[0] = 1'b0;
      stb0 = stbCount;
      err0 = errCount;
      applyStimulus(rb, nb);
      modelApply(rb, nb);
      checkOutput($sformatf("rand%0d.stb", r), 64'(stbCount - stb0), (nb >= 16) ? 64'd1 : 64'd0);
      checkOutput($sformatf("rand%0d.err", r), 64'(errCount - err0), (nb >= 16) ? 64'd0 : 64'd1);
      checkModel($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
